// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot loader, instruction memory and CPU top:
// word width, default memory depth and loader state encodings.
package instr_loader_pkg;

  localparam int INSTR_WIDTH        = 24;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_B0     = 3'd2,
    ST_B1     = 3'd3,
    ST_B2     = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_e;

  typedef enum logic [1:0] {
    LANE_HI   = 2'd0,
    LANE_MID  = 2'd1,
    LANE_LO   = 2'd2,
    LANE_NONE = 2'd3
  } byte_lane_e;

  // Which byte of the instruction word a given loader state is collecting.
  function automatic byte_lane_e lane_of_state(input loader_state_e st);
    byte_lane_e lane;
    case (st)
      ST_B0:   lane = LANE_HI;
      ST_B1:   lane = LANE_MID;
      ST_B2:   lane = LANE_LO;
      default: lane = LANE_NONE;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface instr_loader_if
  import instr_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

  logic [7:0]             InData;
  logic                   InValid;
  logic                   InReady;
  logic                   IMemWrite;
  logic [ADDR_WIDTH-1:0]  IMemAddr;
  logic [INSTR_WIDTH-1:0] IMemData;

  modport slave (
    input  InData, InValid,
    output InReady, IMemWrite, IMemAddr, IMemData
  );

  modport master (
    output InData, InValid,
    input  InReady, IMemWrite, IMemAddr, IMemData
  );

endinterface

// File: rtl/instr_loader_word_assembler.sv
// Packs three big-endian bytes into one instruction word; the low byte is
// passed straight through so the word is available in the cycle it arrives.
module instr_loader_word_assembler
  import instr_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   byte_valid,
  input  byte_lane_e             lane,
  input  logic [7:0]             byte_in,
  output logic [INSTR_WIDTH-1:0] word,
  output logic                   word_complete
);

  logic [7:0] hi_q, hi_d;
  logic [7:0] mid_q, mid_d;

  always_comb begin
    hi_d          = hi_q;
    mid_d         = mid_q;
    word_complete = 1'b0;
    if (byte_valid) begin
      case (lane)
        LANE_HI:  hi_d = byte_in;
        LANE_MID: mid_d = byte_in;
        LANE_LO:  word_complete = 1'b1;
        default:  word_complete = 1'b0;
      endcase
    end else begin
      word_complete = 1'b0;
    end
  end

  assign word = {hi_q, mid_q, byte_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= 8'd0;
      mid_q <= 8'd0;
    end else begin
      hi_q  <= hi_d;
      mid_q <= mid_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: writes a COUNT-prefixed big-endian image into instruction memory
// from address 0 and holds the CPU in reset until the last word is written.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic          Clock,
  input  logic          Reset,
  instr_loader_if.slave bus,
  output logic          CPUHold,
  output logic          Done,
  output logic          Error
);

  // One extra index bit lets COUNT == DEPTH finish without wrapping.
  localparam int          IDX_WIDTH = ADDR_WIDTH + 1;
  localparam logic [16:0] DEPTH_C   = 17'd1 << ADDR_WIDTH;

  loader_state_e          state_q, state_d;
  logic [15:0]            count_q, count_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   imem_write_q, imem_write_d;
  logic [ADDR_WIDTH-1:0]  imem_addr_q, imem_addr_d;
  logic [INSTR_WIDTH-1:0] imem_data_q, imem_data_d;
  logic                   cpu_hold_q, cpu_hold_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic                   in_ready_s;
  logic                   accept_s;
  logic [IDX_WIDTH-1:0]   idx_inc_s;
  logic [15:0]            hdr_count_s;
  byte_lane_e             lane_s;
  logic [INSTR_WIDTH-1:0] asm_word_s;
  logic                   asm_complete_s;

  assign in_ready_s  = !Reset && (state_q != ST_DONE) && (state_q != ST_ERR);
  assign accept_s    = bus.InValid && in_ready_s;
  assign lane_s      = lane_of_state(state_q);
  assign idx_inc_s   = idx_q + IDX_WIDTH'(1);
  assign hdr_count_s = {count_q[15:8], bus.InData};

  instr_loader_word_assembler u_asm (
    .clk           (Clock),
    .rst           (Reset),
    .byte_valid    (accept_s),
    .lane          (lane_s),
    .byte_in       (bus.InData),
    .word          (asm_word_s),
    .word_complete (asm_complete_s)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    imem_write_d = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_data_d  = imem_data_q;
    if (accept_s) begin
      case (state_q)
        ST_HDR_HI: begin
          count_d = {bus.InData, count_q[7:0]};
          state_d = ST_HDR_LO;
        end
        ST_HDR_LO: begin
          count_d = hdr_count_s;
          if (hdr_count_s == 16'd0) begin
            state_d = ST_DONE;
          end else if ({1'b0, hdr_count_s} > DEPTH_C) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_B0;
          end
        end
        ST_B0: state_d = ST_B1;
        ST_B1: state_d = ST_B2;
        ST_B2: begin
          imem_write_d = asm_complete_s;
          imem_addr_d  = idx_q[ADDR_WIDTH-1:0];
          imem_data_d  = asm_word_s;
          idx_d        = idx_inc_s;
          if (16'(idx_inc_s) == count_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_B0;
          end
        end
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end
    // Hold drops one cycle after DONE so the CPU never overlaps the final write.
    cpu_hold_d = (state_q != ST_DONE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_HDR_HI;
      count_q      <= 16'd0;
      idx_q        <= '0;
      imem_write_q <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      imem_write_q <= imem_write_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.InReady   = in_ready_s;
  assign bus.IMemWrite = imem_write_q;
  assign bus.IMemAddr  = imem_addr_q;
  assign bus.IMemData  = imem_data_q;
  assign CPUHold       = cpu_hold_q;
  assign Done          = done_q;
  assign Error         = error_q;

endmodule
